fir_coeff_loader: RTL

Writer for the serial coefficient chain of the FIR filter core. Holds a host-written table of `LENGTH` 8-bit coefficients and, on request, shifts them into the core's `coeffs_in`/`coeffs_shift` chain so that table entry k lands in core stage k. An optional verify pass reads the chain back through the core's `coeffs_out` and flags any mismatch. It sits beside the FIR core and replaces ad-hoc host toggling of the shift pins.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_coeff_table.sv | 58 +++++
 rtl/fir_coeff_loader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR filter core and its coefficient loader.
//   COEFF_W      : width of one filter coefficient
//   COEFF_PAD    : value shifted into the unused last stage of the chain
//   load_state_t : states of the coefficient loader sequencer
//   in_write_window() : true in the states where host table writes are safe
// ---------------------------------------------------------------------------
package fir_pkg;

   localparam int COEFF_W = 8;

   localparam logic [COEFF_W-1:0] COEFF_PAD = '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      VERIFY = 2'd2,
      FINISH = 2'd3
   } load_state_t;

   // The table must not change while a sequence is being shifted out, so
   // host writes are only let through when no shift is in progress.
   function automatic logic in_write_window(input load_state_t s);
      return (s == IDLE) || (s == FINISH);
   endfunction

endpackage

// File: rtl/fir_coeff_table.sv
// ---------------------------------------------------------------------------
// fir_coeff_table
// LENGTH x COEFF_W register file holding the host-written coefficients.
// One synchronous write port, one combinational read port, async clear.
//   clk      in  : clock, rising edge
//   nRst     in  : asynchronous active-low reset, clears every entry to 0
//   wr_en    in  : write strobe (already qualified by the caller)
//   wr_addr  in  : write index; indices >= LENGTH are ignored
//   wr_data  in  : value to store
//   rd_addr  in  : read index; indices >= LENGTH read as COEFF_PAD
//   rd_data  out : combinational read data
// ---------------------------------------------------------------------------
module fir_coeff_table
   import fir_pkg::*;
#(
   parameter int LENGTH = 20,
   parameter int ADDR_W = 5
) (
   input  logic               clk,
   input  logic               nRst,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [COEFF_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [COEFF_W-1:0] rd_data
);

   logic [COEFF_W-1:0] mem [LENGTH];

   // Write port. Each entry compares the address against its own index,
   // which both decodes the write and silently drops out-of-range indices
   // without ever indexing past the end of the array.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         for (int k = 0; k < LENGTH; k++) begin
            mem[k] <= '0;
         end
      end else if (wr_en) begin
         for (int k = 0; k < LENGTH; k++) begin
            if (wr_addr == ADDR_W'(k)) begin
               mem[k] <= wr_data;
            end
         end
      end
   end

   // Read port. A mux over the entries; addresses past the table return the
   // padding value so a stray index can never produce X.
   always_comb begin
      rd_data = COEFF_PAD;
      for (int k = 0; k < LENGTH; k++) begin
         if (rd_addr == ADDR_W'(k)) begin
            rd_data = mem[k];
         end
      end
   end

endmodule

// File: rtl/fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// fir_coeff_loader
// Shifts a host-written coefficient table into the FIR core's serial
// coefficient chain so that table entry k lands in core stage k, and can
// optionally shift the same sequence a second time while checking what
// comes out of the chain.
//   clk        in  : clock, rising edge
//   nRst       in  : asynchronous active-low reset
//   wr_en      in  : table write strobe (dropped while shifting)
//   wr_addr    in  : table index, >= LENGTH ignored
//   wr_data    in  : coefficient value
//   start      in  : load request, honoured only in IDLE
//   verify     in  : sampled with start, adds a read-back pass
//   chain_out  in  : core coeffs_out (last chain stage)
//   shift_en   out : core coeffs_shift
//   shift_data out : core coeffs_in
//   busy       out : high while shifting; core sample must be held low
//   done       out : one-cycle completion pulse
//   err        out : sticky verify mismatch, cleared by the next start
//   err_idx    out : shift index of the first verify mismatch
// ---------------------------------------------------------------------------
module fir_coeff_loader
   import fir_pkg::*;
#(
   parameter int LENGTH = 20,
   parameter int ADDR_W = 5
) (
   input  logic               clk,
   input  logic               nRst,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [COEFF_W-1:0] wr_data,
   input  logic               start,
   input  logic               verify,
   input  logic [COEFF_W-1:0] chain_out,
   output logic               shift_en,
   output logic [COEFF_W-1:0] shift_data,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [ADDR_W:0]    err_idx
);

   localparam int IDX_W = ADDR_W + 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH);

   load_state_t        state;
   logic [IDX_W-1:0]   idx;
   logic               verify_q;
   logic               tbl_wr_en;
   logic [IDX_W-1:0]   next_idx;
   logic [IDX_W-1:0]   rd_idx;
   logic [ADDR_W-1:0]  rd_addr;
   logic [COEFF_W-1:0] rd_data;

   // Host writes are gated here rather than inside the table so the table
   // stays a plain register file and the sequencing rules live in one place.
   assign tbl_wr_en = wr_en && in_write_window(state);

   // shift_data is registered, so while seq[idx] is on the pins the table is
   // already being read for seq[idx+1]. seq[i] for i >= 1 is
   // table[LENGTH-i]: the first value shifted travels furthest down the
   // chain. When idx is LENGTH the read address wraps, but that read is
   // never used because the sequence restarts with the padding value.
   assign next_idx = idx + IDX_W'(1);
   assign rd_idx   = LAST_IDX - next_idx;
   assign rd_addr  = rd_idx[ADDR_W-1:0];

   fir_coeff_table #(
      .LENGTH (LENGTH),
      .ADDR_W (ADDR_W)
   ) u_table (
      .clk     (clk),
      .nRst    (nRst),
      .wr_en   (tbl_wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Sequencer. All outputs are registered and are set one edge ahead, so
   // the first shift is already on the pins in the cycle right after start
   // is accepted and the core sees exactly one shift per cycle with no gaps.
   // The LOAD and VERIFY passes share the same walk through the sequence;
   // VERIFY additionally checks chain_out, which at each shift edge still
   // holds the value that was pushed in LENGTH+1 shifts earlier, i.e. the
   // same seq[idx] that is currently being driven on shift_data.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state      <= IDLE;
         idx        <= '0;
         verify_q   <= 1'b0;
         shift_en   <= 1'b0;
         shift_data <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_idx    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state      <= LOAD;
                  idx        <= '0;
                  verify_q   <= verify;
                  err        <= 1'b0;
                  err_idx    <= '0;
                  shift_en   <= 1'b1;
                  busy       <= 1'b1;
                  shift_data <= COEFF_PAD;
               end
            end

            LOAD, VERIFY: begin
               if ((state == VERIFY) && !err && (chain_out != shift_data)) begin
                  err     <= 1'b1;
                  err_idx <= idx;
               end
               if (idx == LAST_IDX) begin
                  idx        <= '0;
                  shift_data <= COEFF_PAD;
                  if ((state == LOAD) && verify_q) begin
                     state <= VERIFY;
                  end else begin
                     state    <= FINISH;
                     shift_en <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end
               end else begin
                  idx        <= next_idx;
                  shift_data <= rd_data;
               end
            end

            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state    <= IDLE;
               shift_en <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule
